// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs for the add and multiply
// units, round-robin grant, registered broadcast of the winning tag/data.
module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              add_valid,
  output logic              add_ready,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  input  logic              mul_valid,
  output logic              mul_ready,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src
);

  localparam int ENT_W = TAG_W + DATA_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Index 0 is the add source, index 1 the multiply source.
  logic [ENT_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [CNT_W-1:0] count [2];
  logic [ENT_W-1:0] in_entry [2];
  logic [1:0]       in_valid, ready, nonempty, push, pop;
  logic             prio, gnt_any, gnt_src;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_valid    = {mul_valid, add_valid};
    in_entry[0] = {add_tag, add_data};
    in_entry[1] = {mul_tag, mul_data};
    ready       = '0;
    nonempty    = '0;
    push        = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      // Ready looks only at the registered count: no pass-through when full.
      ready[s]    = !rst && (count[s] != FULL);
      nonempty[s] = (count[s] != '0);
      push[s]     = in_valid[s] && ready[s] && !flush;
    end
    gnt_any = |nonempty;
    gnt_src = (&nonempty) ? prio : nonempty[1];
    pop     = {gnt_any && gnt_src, gnt_any && !gnt_src};
    head    = mem[gnt_src][rd_ptr[gnt_src]];
  end

  assign add_ready = ready[0];
  assign mul_ready = ready[1];

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) mem[s][wr_ptr[s]] <= in_entry[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      prio      <= 1'b0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= 1'b0;
    end else if (flush) begin
      // Buffered results are dropped; the last broadcast payload is kept.
      for (int unsigned s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        count[s]  <= '0;
      end
      prio      <= 1'b0;
      cdb_valid <= 1'b0;
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= next_ptr(wr_ptr[s]);
        if (pop[s])  rd_ptr[s] <= next_ptr(rd_ptr[s]);
        if (push[s] && !pop[s])      count[s] <= count[s] + CNT_W'(1);
        else if (pop[s] && !push[s]) count[s] <= count[s] - CNT_W'(1);
      end
      cdb_valid <= gnt_any;
      if (gnt_any) begin
        cdb_tag  <= head[ENT_W-1:DATA_W];
        cdb_data <= head[DATA_W-1:0];
        cdb_src  <= gnt_src;
        prio     <= ~gnt_src;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table for single-cycle behaviour plus
// a hand-written sustained-contention sequence.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        add_valid, mul_valid;
  logic        add_ready, mul_ready;
  logic [4:0]  add_tag, mul_tag;
  logic [31:0] add_data, mul_data;
  logic        cdb_valid, cdb_src;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;

  int checks   = 0;
  int failures = 0;
  int step     = 0;

  cdb_arbiter #(.TAG_W(5), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .add_valid(add_valid), .add_ready(add_ready), .add_tag(add_tag), .add_data(add_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_tag(mul_tag), .mul_data(mul_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush;
    logic        av;
    logic [4:0]  at;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mt;
    logic [31:0] md;
    logic        era, erm;
    logic        ev;
    logic [4:0]  et;
    logic [31:0] ed;
    logic        es;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic f,
                              input logic av, input logic [4:0] at, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mt, input logic [31:0] md,
                              input logic era, input logic erm,
                              input logic ev, input logic [4:0] et, input logic [31:0] ed,
                              input logic es);
    vec_t v;
    v.rst = r; v.flush = f;
    v.av = av; v.at = at; v.ad = ad;
    v.mv = mv; v.mt = mt; v.md = md;
    v.era = era; v.erm = erm;
    v.ev = ev; v.et = et; v.ed = ed; v.es = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    step      = i;
    rst       = vecs[i].rst;
    flush     = vecs[i].flush;
    add_valid = vecs[i].av; add_tag = vecs[i].at; add_data = vecs[i].ad;
    mul_valid = vecs[i].mv; mul_tag = vecs[i].mt; mul_data = vecs[i].md;
    #1;
    check("add_ready", 32'(add_ready), 32'(vecs[i].era));
    check("mul_ready", 32'(mul_ready), 32'(vecs[i].erm));
    @(posedge clk); #1;
    check("cdb_valid", 32'(cdb_valid), 32'(vecs[i].ev));
    check("cdb_tag",   32'(cdb_tag),   32'(vecs[i].et));
    check("cdb_data",  cdb_data,       vecs[i].ed);
    check("cdb_src",   32'(cdb_src),   32'(vecs[i].es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] at, mt;
    logic       hs_a, hs_m, exp_src;
    logic [4:0] exp_tag;

    //            rst f  av at  ad       mv mt  md       era erm ev et  ed       es
    vecs[0]  = mk(1, 0, 0, 0,  0,       0, 0,  0,       0,  0,  0, 0,  0,       0);
    vecs[1]  = mk(1, 0, 0, 0,  0,       0, 0,  0,       0,  0,  0, 0,  0,       0);
    vecs[2]  = mk(0, 0, 1, 3,  'h10,    0, 0,  0,       1,  1,  0, 0,  0,       0);
    vecs[3]  = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 3,  'h10,    0);
    vecs[4]  = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 3,  'h10,    0);
    vecs[5]  = mk(0, 1, 0, 0,  0,       0, 0,  0,       1,  1,  0, 3,  'h10,    0);
    vecs[6]  = mk(0, 0, 1, 1,  'hA,     1, 2,  'hB,     1,  1,  0, 3,  'h10,    0);
    vecs[7]  = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 1,  'hA,     0);
    vecs[8]  = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 2,  'hB,     1);
    vecs[9]  = mk(0, 0, 1, 4,  'hC,     1, 5,  'hD,     1,  1,  0, 2,  'hB,     1);
    vecs[10] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 4,  'hC,     0);
    vecs[11] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 5,  'hD,     1);
    vecs[12] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 5,  'hD,     1);
    // After the contention run: add holds 2, mul holds 1, last broadcast mul tag 29.
    vecs[13] = mk(0, 1, 1, 9,  'h99,    0, 0,  0,       0,  1,  0, 29, 'h11D,   1);
    vecs[14] = mk(0, 0, 0, 0,  0,       1, 0,  'h77,    1,  1,  0, 29, 'h11D,   1);
    vecs[15] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  1, 0,  'h77,    1);
    vecs[16] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 0,  'h77,    1);
    vecs[17] = mk(0, 1, 1, 9,  'h99,    0, 0,  0,       1,  1,  0, 0,  'h77,    1);
    vecs[18] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 0,  'h77,    1);
    vecs[19] = mk(0, 0, 1, 21, 'h150,   1, 22, 'h160,   1,  1,  0, 0,  'h77,    1);
    vecs[20] = mk(0, 0, 1, 23, 'h170,   1, 24, 'h180,   1,  1,  1, 21, 'h150,   0);
    vecs[21] = mk(1, 0, 0, 0,  0,       0, 0,  0,       0,  0,  0, 0,  0,       0);
    vecs[22] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 0,  0,       0);
    vecs[23] = mk(0, 0, 0, 0,  0,       0, 0,  0,       1,  1,  0, 0,  0,       0);

    for (int i = 0; i <= 12; i++) run_vec(i);

    // Sustained contention: both sources always valid, tags advance on acceptance.
    at = 5'd20;
    mt = 5'd26;
    for (int k = 0; k <= 8; k++) begin
      step      = 100 + k;
      rst       = 1'b0;
      flush     = 1'b0;
      add_valid = 1'b1; add_tag = at; add_data = 32'h100 + 32'(at);
      mul_valid = 1'b1; mul_tag = mt; mul_data = 32'h100 + 32'(mt);
      #1;
      check("bp_add_ready", 32'(add_ready), (k < 2) ? 32'd1 : 32'((k % 2) == 0));
      check("bp_mul_ready", 32'(mul_ready), (k < 2) ? 32'd1 : 32'((k % 2) == 1));
      hs_a = add_ready;
      hs_m = mul_ready;
      @(posedge clk); #1;
      if (k == 0) begin
        check("bp_cdb_valid", 32'(cdb_valid), 32'd0);
      end else begin
        exp_src = ((k - 1) % 2) == 1;
        exp_tag = exp_src ? 5'(26 + (k - 1) / 2) : 5'(20 + (k - 1) / 2);
        check("bp_cdb_valid", 32'(cdb_valid), 32'd1);
        check("bp_cdb_src",   32'(cdb_src),   32'(exp_src));
        check("bp_cdb_tag",   32'(cdb_tag),   32'(exp_tag));
        check("bp_cdb_data",  cdb_data,       32'h100 + 32'(exp_tag));
      end
      if (hs_a) at = at + 5'd1;
      if (hs_m) mt = mt + 5'd1;
    end

    for (int i = 13; i <= 23; i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
